// File: rtl/clz_pipe_pkg.sv
// Shared types and helpers for the pipelined leading/trailing zero/one counter.
// Provides the mode enum, count-width function, leaf encoder and operand transform.
package clz_pkg;

    typedef enum logic [1:0] {
        CLZ = 2'd0,
        CLO = 2'd1,
        CTZ = 2'd2,
        CTO = 2'd3
    } clz_mode_e;

    function automatic int cw(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic logic [1:0] leaf_enc(input logic [1:0] g);
        case (g)
            2'b00:   return 2'd2;
            2'b01:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // One bit of the mode-transformed operand; afterwards every mode is a CLZ.
    function automatic logic xform_bit(input logic [127:0] d, input int unsigned width,
                                       input int unsigned i, input clz_mode_e m);
        logic [6:0] idx;
        logic       b;
        idx = (m == CTZ || m == CTO) ? 7'(width - 1 - i) : 7'(i);
        b   = d[idx];
        return (m == CLO || m == CTO) ? ~b : b;
    endfunction

endpackage

// File: rtl/clz_pipe_if.sv
// Operand/result handshake bundle for clz_pipe.
// master drives operands and out_ready; slave is the counter pipeline.
interface clz_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
);
    import clz_pkg::*;

    localparam int CW = cw(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    clz_mode_e        in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_all;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_count, out_all, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_count, out_all, out_tag
    );

endinterface

// File: rtl/clz_pipe_merge.sv
// One combinational merge level: pairs of leading-zero counts of width-2^k groups
// are combined into counts for groups twice as wide.
module clz_merge #(
    parameter int GROUPS = 2,
    parameter int CNT_W  = 2
) (
    input  logic [GROUPS*CNT_W-1:0]         in_cnt,
    output logic [(GROUPS/2)*(CNT_W+1)-1:0] out_cnt
);
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] lo;

    // hi's MSB set means hi == 2^k, i.e. the upper group was all zero.
    always_comb begin
        out_cnt = '0;
        hi      = '0;
        lo      = '0;
        for (int unsigned j = 0; j < GROUPS / 2; j++) begin
            hi = in_cnt[(2*j+1)*CNT_W +: CNT_W];
            lo = in_cnt[(2*j)*CNT_W +: CNT_W];
            out_cnt[j*(CNT_W+1) +: CNT_W+1] = hi[CNT_W-1] ? ({1'b0, hi} + {1'b0, lo})
                                                          : {1'b0, hi};
        end
    end

endmodule

// File: rtl/clz_pipe.sv
// Pipelined leading/trailing zero/one counter: leaf level plus log2(WIDTH)-1 merge
// levels, each registered, advancing as a unit under valid/ready flow control.
module clz_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
) (
    input  logic      clk,
    input  logic      reset,
    clz_pipe_if.slave bus
);
    import clz_pkg::*;

    localparam int L  = $clog2(WIDTH);
    localparam int CW = cw(WIDTH);

    logic             advance;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] leaf_cnt;

    assign advance      = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = advance & ~reset;

    for (genvar i = 0; i < WIDTH; i++) begin : g_xform
        assign op_x[i] = xform_bit(128'(bus.in_data), WIDTH, i, bus.in_mode);
    end

    for (genvar g = 0; g < WIDTH / 2; g++) begin : g_leaf_enc
        assign leaf_cnt[2*g +: 2] = leaf_enc(op_x[2*g +: 2]);
    end

    // Stage s holds WIDTH>>(s+1) counts of s+2 bits each.
    for (genvar s = 0; s < L; s++) begin : g_stage
        localparam int GO = WIDTH >> (s + 1);
        localparam int CO = s + 2;

        logic [GO*CO-1:0] cnt_q, cnt_d;
        logic [TAG_W-1:0] tag_q, tag_d;
        logic             vld_q, vld_d;

        if (s == 0) begin : g_src
            assign cnt_d = leaf_cnt;
            assign tag_d = bus.in_tag;
            assign vld_d = bus.in_valid & bus.in_ready;
        end else begin : g_src
            clz_merge #(
                .GROUPS(WIDTH >> s),
                .CNT_W (s + 1)
            ) u_merge (
                .in_cnt (g_stage[s-1].cnt_q),
                .out_cnt(cnt_d)
            );
            assign tag_d = g_stage[s-1].tag_q;
            assign vld_d = g_stage[s-1].vld_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
                tag_q <= '0;
                vld_q <= 1'b0;
            end else if (advance) begin
                cnt_q <= cnt_d;
                tag_q <= tag_d;
                vld_q <= vld_d;
            end
        end
    end

    assign bus.out_valid = g_stage[L-1].vld_q;
    assign bus.out_count = g_stage[L-1].cnt_q;
    assign bus.out_tag   = g_stage[L-1].tag_q;
    assign bus.out_all   = (g_stage[L-1].cnt_q == CW'(WIDTH));

endmodule

// File: tb/tb_clz_pipe.sv
// Bench for clz_pipe: 32-bit and 16-bit instances, directed vectors, sweep,
// backpressure, mid-stream reset and a random soak against a scan-based reference.
module tb_clz_pipe;
    import clz_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int         cnt;
        logic [7:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        clz_mode_e   m;
        logic [7:0]  t;
        int          cnt;
        logic        all;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    int   dlv_a = 0;

    clz_pipe_if #(.WIDTH(32), .TAG_W(8)) a_if ();
    clz_pipe_if #(.WIDTH(16), .TAG_W(8)) b_if ();

    clz_pipe #(.WIDTH(32), .TAG_W(8)) u_a (.clk(clk), .reset(reset), .bus(a_if));
    clz_pipe #(.WIDTH(16), .TAG_W(8)) u_b (.clk(clk), .reset(reset), .bus(b_if));

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the operand from the scan end until the bit stops matching.
    function automatic int ref_count(input logic [127:0] d, input int w, input clz_mode_e m);
        int  n = 0;
        int  pos;
        logic target;
        target = (m == CLO || m == CTO);
        for (int i = 0; i < w; i++) begin
            pos = (m == CLZ || m == CLO) ? (w - 1 - i) : i;
            if (d[pos] != target) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [127:0] gen(input int w);
        logic [127:0] r;
        int k;
        r = {$urandom, $urandom, $urandom, $urandom};
        k = $urandom_range(0, w);
        case ($urandom_range(0, 4))
            0:       return r;
            1:       return (r >> (128 - w)) >> k;
            2:       return ~((r >> (128 - w)) >> k);
            3:       return r << k;
            default: return ~(r << k);
        endcase
    endfunction

    // Monitors: sample at negedge, score accepts and deliveries, check hold stability.
    logic       a_held = 1'b0, b_held = 1'b0;
    int         a_pc, b_pc;
    logic [7:0] a_pt, b_pt;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_held) begin
            chk("a_hold_valid", a_if.out_valid, 1);
            chk("a_hold_count", a_if.out_count, a_pc);
            chk("a_hold_tag", a_if.out_tag, a_pt);
        end
        a_held = a_if.out_valid & ~a_if.out_ready & ~reset;
        a_pc = a_if.out_count;
        a_pt = a_if.out_tag;
        if (reset) qa.delete();
        else begin
            if (a_if.out_valid && a_if.out_ready) begin
                if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_count", a_if.out_count, e.cnt);
                    chk("a_all", a_if.out_all, (e.cnt == 32) ? 1 : 0);
                    chk("a_tag", a_if.out_tag, e.tag);
                    dlv_a++;
                end
            end
            if (a_if.in_valid && a_if.in_ready)
                qa.push_back('{ref_count(128'(a_if.in_data), 32, a_if.in_mode), a_if.in_tag});
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_held) begin
            chk("b_hold_valid", b_if.out_valid, 1);
            chk("b_hold_count", b_if.out_count, b_pc);
            chk("b_hold_tag", b_if.out_tag, b_pt);
        end
        b_held = b_if.out_valid & ~b_if.out_ready & ~reset;
        b_pc = b_if.out_count;
        b_pt = b_if.out_tag;
        if (reset) qb.delete();
        else begin
            if (b_if.out_valid && b_if.out_ready) begin
                if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_count", b_if.out_count, e.cnt);
                    chk("b_all", b_if.out_all, (e.cnt == 16) ? 1 : 0);
                    chk("b_tag", b_if.out_tag, e.tag);
                end
            end
            if (b_if.in_valid && b_if.in_ready)
                qb.push_back('{ref_count(128'(b_if.in_data), 16, b_if.in_mode), b_if.in_tag});
        end
    end

    task automatic drive_a(input logic v, input logic [31:0] d, input clz_mode_e m, input logic [7:0] t);
        a_if.in_valid = v;
        a_if.in_data  = d;
        a_if.in_mode  = m;
        a_if.in_tag   = t;
    endtask

    task automatic drive_b(input logic v, input logic [15:0] d, input clz_mode_e m, input logic [7:0] t);
        b_if.in_valid = v;
        b_if.in_data  = d;
        b_if.in_mode  = m;
        b_if.in_tag   = t;
    endtask

    // Single operand on the 32-bit instance; returns latency and the result seen.
    task automatic send_one_a(input logic [31:0] d, input clz_mode_e m, input logic [7:0] t,
                              output int lat, output int cnt, output int all, output int tag);
        @(posedge clk); #1;
        drive_a(1'b1, d, m, t);
        a_if.out_ready = 1'b1;
        @(negedge clk);
        chk("accept_ready", a_if.in_ready, 1);
        @(posedge clk); #1;
        drive_a(1'b0, '0, CLZ, '0);
        lat = -1; cnt = -1; all = -1; tag = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (a_if.out_valid) begin
                lat = n; cnt = a_if.out_count; all = a_if.out_all; tag = a_if.out_tag;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        vec_t vt[14];
        int lat, cnt, all, tag;
        int k, last, first, sent, held_cnt, d0, nacc;
        logic acc, released;
        logic [127:0] r;

        vt = '{
            '{32'h0001_0000, CLZ, 8'h5A, 15, 1'b0},
            '{32'hFFFF_FFFF, CLO, 8'h11, 32, 1'b1},
            '{32'h8000_0000, CTZ, 8'h22, 31, 1'b0},
            '{32'h0000_000F, CTO, 8'h33,  4, 1'b0},
            '{32'h0000_0000, CLZ, 8'h44, 32, 1'b1},
            '{32'h8000_0000, CLZ, 8'h55,  0, 1'b0},
            '{32'h0000_0001, CTZ, 8'h66,  0, 1'b0},
            '{32'h7FFF_FFFF, CLO, 8'h77,  0, 1'b0},
            '{32'hF000_0000, CLO, 8'h88,  4, 1'b0},
            '{32'hFFFF_FFFE, CTO, 8'h99,  0, 1'b0},
            '{32'h0000_0000, CTO, 8'hA5,  0, 1'b0},
            '{32'hFFFF_FFFF, CTZ, 8'h3C,  0, 1'b0},
            '{32'h0000_0100, CLZ, 8'hC3, 23, 1'b0},
            '{32'h0000_0000, CTZ, 8'h0F, 32, 1'b1}
        };

        drive_a(1'b0, '0, CLZ, '0);
        drive_b(1'b0, '0, CLZ, '0);
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", a_if.out_valid, 0);
        chk("rst_out_count", a_if.out_count, 0);
        chk("rst_out_all", a_if.out_all, 0);
        chk("rst_out_tag", a_if.out_tag, 0);
        chk("rst_in_ready", a_if.in_ready, 1);
        chk("rst_b_out_valid", b_if.out_valid, 0);

        for (int i = 0; i < 14; i++) begin
            send_one_a(vt[i].d, vt[i].m, vt[i].t, lat, cnt, all, tag);
            chk("vec_latency", lat, 5);
            chk("vec_count", cnt, vt[i].cnt);
            chk("vec_all", all, vt[i].all);
            chk("vec_tag", tag, vt[i].t);
        end

        // Sweep on the 16-bit instance: one-hot operands back to back, then zero.
        k = 0; last = 0; first = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (c < 17) drive_b(1'b1, (c < 16) ? 16'(1 << c) : 16'h0000, CLZ, 8'(c));
            else        drive_b(1'b0, '0, CLZ, '0);
            @(negedge clk);
            if (b_if.out_valid) begin
                chk("sweep_count", b_if.out_count, (k < 16) ? 15 - k : 16);
                chk("sweep_all", b_if.out_all, (k == 16) ? 1 : 0);
                if (k == 0) first = c;
                else chk("sweep_gap", c - last, 1);
                last = c;
                k++;
            end
        end
        chk("sweep_total", k, 17);
        chk("sweep_latency", first, 4);

        // Backpressure: pipe fills with out_ready low, stall 10 cycles once out_valid rises.
        sent = 0; held_cnt = 0; d0 = dlv_a; acc = 1'b0; released = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (acc) sent++;
            r = gen(32);
            if (sent < 8) drive_a(1'b1, r[31:0], clz_mode_e'($urandom_range(0, 3)), 8'($urandom));
            else          drive_a(1'b0, '0, CLZ, '0);
            a_if.out_ready = released;
            @(negedge clk);
            acc = a_if.in_valid & a_if.in_ready;
            if (a_if.out_valid && !released) begin
                chk("bp_in_ready", a_if.in_ready, 0);
                held_cnt++;
                if (held_cnt == 10) released = 1'b1;
            end
            if (released && sent == 8 && (dlv_a - d0) == 8) break;
        end
        chk("bp_stall_cycles", held_cnt, 10);
        chk("bp_delivered", dlv_a - d0, 8);

        // Reset with three operands in flight.
        a_if.out_ready = 1'b1;
        d0 = dlv_a;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive_a(1'b1, 32'h0000_0001 << i, CLZ, 8'(8'hE0 + i));
        end
        @(posedge clk); #1;
        drive_a(1'b0, '0, CLZ, '0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready_low", a_if.in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_high", a_if.in_ready, 1);
        chk("midrst_out_count", a_if.out_count, 0);
        for (int i = 0; i < 8; i++) begin
            chk("midrst_no_valid", a_if.out_valid, 0);
            @(negedge clk);
        end
        chk("midrst_no_delivery", dlv_a - d0, 0);
        send_one_a(32'h0000_0100, CLZ, 8'h7E, lat, cnt, all, tag);
        chk("midrst_latency", lat, 5);
        chk("midrst_count", cnt, 23);
        chk("midrst_tag", tag, 8'h7E);

        // Random soak on both instances.
        nacc = 0;
        for (int c = 0; c < 60000 && nacc < 10000; c++) begin
            @(posedge clk); #1;
            r = gen(32);
            drive_a($urandom_range(0, 3) != 0, r[31:0], clz_mode_e'($urandom_range(0, 3)), 8'($urandom));
            a_if.out_ready = ($urandom_range(0, 3) != 0);
            r = gen(16);
            drive_b($urandom_range(0, 3) != 0, r[15:0], clz_mode_e'($urandom_range(0, 3)), 8'($urandom));
            b_if.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (a_if.in_valid && a_if.in_ready) nacc++;
        end
        @(posedge clk); #1;
        drive_a(1'b0, '0, CLZ, '0);
        drive_b(1'b0, '0, CLZ, '0);
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("soak_accepts", nacc, 10000);
        chk("soak_a_drained", qa.size(), 0);
        chk("soak_b_drained", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
